frame_reader: RTL and testbench

FRAME_READER -- requirements
Module: frame_reader

---
 rtl/frame_reader_pkg.sv | 22 ++
 rtl/frame_reader_crc.sv | 21 ++
 rtl/frame_reader.sv | 190 +++++++++++++++++++
 tb/tb_frame_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_reader_pkg.sv
// Shared definitions for the frame reader: FSM state encoding, frame header
// layout constants and CRC-16/MODBUS parameters.
package frame_reader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        HOLD   = 3'd2,
        CRC_LO = 3'd3,
        CRC_HI = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Frame length = length byte (at LEN_IDX) + HDR_LEN
    localparam int unsigned HDR_LEN = 3;
    localparam int unsigned LEN_IDX = 2;

    // CRC-16/MODBUS, reflected polynomial
    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/frame_reader_crc.sv
// crc16_byte: combinational CRC-16/MODBUS update for one byte, LSB first.
// Only present when FRAME_READER_CRC_EN is defined.
`ifdef FRAME_READER_CRC_EN
module crc16_byte
    import frame_reader_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    // Fold the byte into the low half, then shift out eight bits
    always_comb begin
        crc_out = crc_in ^ {8'h00, data};
        for (int unsigned i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule
`endif

// File: rtl/frame_reader.sv
// frame_reader: streams one committed ping-pong buffer page out as a frame.
// Byte 2 of the page holds the payload length; the frame is length+3 bytes,
// clamped to the page size. Optional macro FRAME_READER_CRC_EN appends a
// CRC-16/MODBUS (low byte, then high byte) after the data bytes.
module frame_reader
    import frame_reader_pkg::*;
#(
    parameter int unsigned A_WIDTH = 8
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               unread,
    input  logic [7:0]         rd_byte,
    output logic [A_WIDTH-1:0] rd_addr,
    output logic               rd_done,
    input  logic               abort,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

    localparam int unsigned TW = A_WIDTH + 1;

    state_t             state, state_d;
    logic [A_WIDTH-1:0] idx, idx_d, rd_addr_d;
    logic [TW-1:0]      total, total_d, total_now;
    logic [7:0]         out_data_d;
    logic               out_valid_d, out_last_d;
    logic               data_last, data_last_d;
    logic               last_now, xfer;

`ifdef FRAME_READER_CRC_EN
    logic [15:0] crc, crc_d, crc_next;

    crc16_byte u_crc (
        .crc_in  (crc),
        .data    (out_data),
        .crc_out (crc_next)
    );
`endif

    assign xfer    = out_valid & out_ready;
    assign busy    = (state != IDLE);
    assign rd_done = (state == DONE) & ~abort;

    // While fetching the length byte itself, total is not latched yet, so the
    // length is taken straight from the buffer to catch a 3-byte frame.
    assign total_now = (idx == A_WIDTH'(LEN_IDX)) ? (TW'(rd_byte) + TW'(HDR_LEN)) : total;
    // The last page address always ends the frame, which clamps oversize lengths
    assign last_now  = (&idx) |
                       ((idx >= A_WIDTH'(LEN_IDX)) & ({1'b0, idx} == (total_now - TW'(1))));

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            rd_addr   <= '0;
            total     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            data_last <= 1'b0;
`ifdef FRAME_READER_CRC_EN
            crc       <= CRC_INIT;
`endif
        end else begin
            idx       <= idx_d;
            rd_addr   <= rd_addr_d;
            total     <= total_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            data_last <= data_last_d;
`ifdef FRAME_READER_CRC_EN
            crc       <= crc_d;
`endif
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        rd_addr_d   = rd_addr;
        total_d     = total;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        data_last_d = data_last;
`ifdef FRAME_READER_CRC_EN
        crc_d       = crc;
`endif
        if (abort) begin
            state_d     = IDLE;
            idx_d       = '0;
            rd_addr_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            data_last_d = 1'b0;
`ifdef FRAME_READER_CRC_EN
            crc_d       = CRC_INIT;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (unread) begin
                        state_d   = FETCH;
                        idx_d     = '0;
                        rd_addr_d = '0;
`ifdef FRAME_READER_CRC_EN
                        crc_d     = CRC_INIT;
`endif
                    end
                end
                FETCH: begin
                    out_data_d  = rd_byte;
                    out_valid_d = 1'b1;
                    data_last_d = last_now;
`ifdef FRAME_READER_CRC_EN
                    out_last_d  = 1'b0;
`else
                    out_last_d  = last_now;
`endif
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (xfer) begin
                        // out_data holds the length byte at this index
                        if (idx == A_WIDTH'(LEN_IDX)) begin
                            total_d = TW'(out_data) + TW'(HDR_LEN);
                        end
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
`ifdef FRAME_READER_CRC_EN
                        crc_d       = crc_next;
`endif
                        if (data_last) begin
`ifdef FRAME_READER_CRC_EN
                            out_data_d  = crc_next[7:0];
                            out_valid_d = 1'b1;
                            state_d     = CRC_LO;
`else
                            state_d     = DONE;
`endif
                        end else begin
                            idx_d     = idx + 1'b1;
                            rd_addr_d = idx + 1'b1;
                            state_d   = FETCH;
                        end
                    end
                end
`ifdef FRAME_READER_CRC_EN
                CRC_LO: begin
                    if (xfer) begin
                        out_data_d = crc[15:8];
                        out_last_d = 1'b1;
                        state_d    = CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (xfer) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = DONE;
                    end
                end
`endif
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: a two-slot page buffer model feeds the
// DUT and a reference model derives each expected frame from the page bytes.
module tb_frame_reader;

`ifdef FRAME_READER_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int CRC_BYTES = CRC_EN ? 2 : 0;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         addr;  // -1 for CRC bytes
        bit         fin;   // final data byte of the frame
    } item_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       unread;
    logic [7:0] rd_byte;
    logic [7:0] rd_addr;
    logic       rd_done;
    logic       abort;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    logic [7:0] page_mem [2][256];
    int         commits  = 0;
    int         releases = 0;
    int         loaded_rel = -1;
    item_t      exp_q[$];
    int         frame_bytes = 0;
    int         last_frame_bytes = 0;
    int         last_data_addr = -1;
    bit         prev_done = 1'b0;
    bit         rand_ready = 1'b0;
    bit         forced_ready = 1'b0;
    bit         rand_abort = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       rd_slot;

    assign rd_slot = releases[0];
    assign unread  = (commits != releases);
    assign rd_byte = page_mem[rd_slot][rd_addr];

    frame_reader #(.A_WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .unread    (unread),
        .rd_byte   (rd_byte),
        .rd_addr   (rd_addr),
        .rd_done   (rd_done),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: bytes 0..len-1 with len = min(page[2]+3, 256), then a
    // bit-serial CRC-16/MODBUS over those bytes when CRC is compiled in.
    task automatic load_frame(input int slot);
        int          len;
        logic [15:0] crc;
        logic [7:0]  b;
        bit          fb;
        item_t       it;
        exp_q.delete();
        len = int'(page_mem[slot][2]) + 3;
        if (len > 256) len = 256;
        crc = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            b = page_mem[slot][i];
            for (int k = 0; k < 8; k++) begin
                fb  = crc[0] ^ b[k];
                crc = crc >> 1;
                if (fb) crc = crc ^ 16'hA001;
            end
            it.data = b;
            it.last = !CRC_EN && (i == len - 1);
            it.addr = i;
            it.fin  = (i == len - 1);
            exp_q.push_back(it);
        end
        if (CRC_EN) begin
            it.data = crc[7:0];  it.last = 1'b0; it.addr = -1; it.fin = 1'b0;
            exp_q.push_back(it);
            it.data = crc[15:8]; it.last = 1'b1; it.addr = -1; it.fin = 1'b0;
            exp_q.push_back(it);
        end
    endtask

    // Downstream ready: random or directed, updated just after each rising edge
    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = forced_ready;
    end

    // Monitor: compare every accepted byte and every page release with the model
    always @(negedge clk) begin
        item_t e;
        if (prev_done) check("idle_after_done", 32'(busy), 32'd0);
        prev_done = 1'b0;
        if (!reset_n) begin
            loaded_rel = -1;
        end else begin
            if (commits != releases && loaded_rel != releases) begin
                load_frame(int'(rd_slot));
                loaded_rel  = releases;
                frame_bytes = 0;
            end
            if (abort) begin
                loaded_rel = -1;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_byte", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", 32'(out_data), 32'(e.data));
                        check("last", 32'(out_last), 32'(e.last));
                        if (e.addr >= 0) check("addr", 32'(rd_addr), e.addr);
                        if (e.fin) last_data_addr = int'(rd_addr);
                    end
                    frame_bytes++;
                end
                if (rd_done) begin
                    check("frame_complete", 32'(exp_q.size()), 32'd0);
                    last_frame_bytes = frame_bytes;
                    releases++;
                    prev_done = 1'b1;
                end
            end
        end
    end

    task automatic prep_page(input logic [7:0] len);
        for (int i = 0; i < 256; i++) page_mem[commits[0]][i] = 8'($urandom);
        page_mem[commits[0]][2] = len;
    endtask

    task automatic wait_fetch(input int addr, input string tag);
        bit found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (busy && !out_valid && int'(rd_addr) == addr) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done = 1'b0;
        int aborts_left = 1;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk);
            #1;
            abort = 1'b0;
            if (rand_abort && aborts_left > 0 && busy && $urandom_range(0, 31) == 0) begin
                abort = 1'b1;
                aborts_left--;
            end
            if (commits == releases && !busy && !abort) done = 1'b1;
        end
        abort = 1'b0;
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rel0;
        reset_n = 1'b0;
        abort   = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++) page_mem[s][i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rd_addr",   32'(rd_addr),   32'd0);
        check("rst_rd_done",   32'(rd_done),   32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        forced_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic 5-byte page
        prep_page(8'h02);
        page_mem[commits[0]][0] = 8'h01; page_mem[commits[0]][1] = 8'h02;
        page_mem[commits[0]][3] = 8'hAA; page_mem[commits[0]][4] = 8'hBB;
        commits++;
        wait_idle(200, "a_timeout");
        check("a_bytes", 32'(last_frame_bytes), 32'(5 + CRC_BYTES));
        check("a_releases", 32'(releases), 32'd1);

        // Backpressure on byte 3
        prep_page(8'h02);
        page_mem[commits[0]][0] = 8'h01; page_mem[commits[0]][1] = 8'h02;
        page_mem[commits[0]][3] = 8'hAA; page_mem[commits[0]][4] = 8'hBB;
        commits++;
        wait_fetch(3, "b_reach_idx3");
        @(posedge clk); #1;
        forced_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("b_stall_valid", 32'(out_valid), 32'd1);
            check("b_stall_data",  32'(out_data),  32'hAA);
            check("b_stall_addr",  32'(rd_addr),   32'd3);
        end
        forced_ready = 1'b1;
        wait_idle(200, "b_timeout");
        check("b_releases", 32'(releases), 32'd2);

        // Abort while byte 3 is on offer with ready high
        prep_page(8'h02);
        page_mem[commits[0]][0] = 8'h01; page_mem[commits[0]][1] = 8'h02;
        page_mem[commits[0]][3] = 8'hAA; page_mem[commits[0]][4] = 8'hBB;
        commits++;
        wait_fetch(3, "c_reach_idx3");
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check("c_abort_no_done", 32'(rd_done), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("c_valid_dropped", 32'(out_valid), 32'd0);
        check("c_idle", 32'(busy), 32'd0);
        check("c_no_release", 32'(releases), 32'd2);
        wait_idle(200, "c_timeout");
        check("c_releases", 32'(releases), 32'd3);
        check("c_bytes", 32'(last_frame_bytes), 32'(5 + CRC_BYTES));

        // Reset in the middle of a frame
        prep_page(8'h06);
        commits++;
        wait_fetch(2, "d_reach_idx2");
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("d_rst_valid", 32'(out_valid), 32'd0);
        check("d_rst_busy",  32'(busy),      32'd0);
        check("d_rst_done",  32'(rd_done),   32'd0);
        check("d_rst_addr",  32'(rd_addr),   32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_idle(200, "d_timeout");
        check("d_releases", 32'(releases), 32'd4);
        check("d_bytes", 32'(last_frame_bytes), 32'(9 + CRC_BYTES));

        // Maximum length byte: clamped to the 256-byte page
        prep_page(8'hFF);
        commits++;
        wait_idle(1000, "e_timeout");
        check("e_bytes", 32'(last_frame_bytes), 32'(256 + CRC_BYTES));
        check("e_last_addr", 32'(last_data_addr), 32'd255);

        // Two pages committed back to back
        rel0 = releases;
        prep_page(8'($urandom_range(0, 12)));
        commits++;
        prep_page(8'($urandom_range(0, 12)));
        commits++;
        wait_idle(400, "f_timeout");
        check("f_releases", 32'(releases - rel0), 32'd2);

        // Randomized frames, random backpressure and occasional aborts
        rand_ready = 1'b1;
        rand_abort = 1'b1;
        for (int t = 0; t < 16; t++) begin
            int np;
            rel0 = releases;
            np = $urandom_range(1, 2);
            for (int p = 0; p < np; p++) begin
                if ($urandom_range(0, 9) == 0) prep_page(8'hFF);
                else                           prep_page(8'($urandom_range(0, 30)));
                commits++;
            end
            wait_idle(4000, "r_timeout");
            check("r_releases", 32'(releases - rel0), 32'(np));
        end
        rand_abort = 1'b0;
        rand_ready = 1'b0;

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
